pwm_sequencer: RTL and testbench

- Profile scheduler that drives the configuration inputs of the pwm generator from a small programmable table.
- Each table entry holds Period, DutyCycle, Burst, BurstType and a pulse count. The block applies entries in order and advances after the requested number of PwmIn rising edges.
- Supports one-shot or looped playback.
- Sits between the host/register interface and pwm. Also gates the pwm block's run enable.

---
 rtl/pwm_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pwm_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// Profile scheduler: plays a programmable table of pwm settings, advancing after N PwmIn rises.
// Latency: settings appear 2 cycles after Start is sampled; 1 LOAD cycle between consecutive steps.
// Backpressure: none; Stop aborts at the next edge, writes are accepted in any state.
//
// Ports:
//   SysClk, Reset        clock (posedge) and asynchronous active-low reset
//   Wr*                  table write port (entry WrAddr written when WrEn=1)
//   Length, Loop         number of entries to play and loop/one-shot select
//   Start, Stop          playback control (Start level-sampled in IDLE, Stop has priority)
//   PwmIn                pwm output fed back; its rising edges pace the steps
//   Period..BurstType    registered pwm configuration, updated only in LOAD
//   PwmRun, Busy, Done   pwm run enable, playback active, end-of-one-shot pulse
//   StepIdx              table entry currently applied
module pwm_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [15:0]      WrPeriod,
    input  logic [7:0]       WrDuty,
    input  logic             WrBurst,
    input  logic             WrBurstType,
    input  logic [CNT_W-1:0] WrCount,
    input  logic [AW:0]      Length,
    input  logic             Loop,
    input  logic             Start,
    input  logic             Stop,
    input  logic             PwmIn,
    output logic [15:0]      Period,
    output logic [7:0]       DutyCycle,
    output logic             Burst,
    output logic             BurstType,
    output logic             PwmRun,
    output logic [AW-1:0]    StepIdx,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [AW:0]      DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Profile table
    logic [15:0]      tbl_period_q [DEPTH];
    logic [7:0]       tbl_duty_q   [DEPTH];
    logic             tbl_burst_q  [DEPTH];
    logic             tbl_btype_q  [DEPTH];
    logic [CNT_W-1:0] tbl_count_q  [DEPTH];

    state_t           state_q;
    logic             pwm_in_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      period_q;
    logic [7:0]       duty_q;
    logic             burst_q;
    logic             btype_q;
    logic             run_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;

    logic             rise;
    logic [AW:0]      eff_len;
    logic             has_next;
    logic [7:0]       ld_duty;
    logic [CNT_W-1:0] ld_count;

    assign rise     = PwmIn & ~pwm_in_q;
    assign eff_len  = (Length > DEPTH_L) ? DEPTH_L : Length;
    // Written as idx+1 < len so a Length shrunk below the current index ends playback
    assign has_next = (({1'b0, idx_q} + (AW + 1)'(1)) < eff_len);
    assign ld_duty  = (tbl_duty_q[idx_q] > 8'd100) ? 8'd100 : tbl_duty_q[idx_q];
    assign ld_count = (tbl_count_q[idx_q] == '0) ? CNT_ONE : tbl_count_q[idx_q];

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_period_q[i] <= '0;
                tbl_duty_q[i]   <= '0;
                tbl_burst_q[i]  <= 1'b0;
                tbl_btype_q[i]  <= 1'b0;
                tbl_count_q[i]  <= '0;
            end
        end else if (WrEn) begin
            tbl_period_q[WrAddr] <= WrPeriod;
            tbl_duty_q[WrAddr]   <= WrDuty;
            tbl_burst_q[WrAddr]  <= WrBurst;
            tbl_btype_q[WrAddr]  <= WrBurstType;
            tbl_count_q[WrAddr]  <= WrCount;
        end
    end

    always_ff @(posedge SysClk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            pwm_in_q <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            duty_q   <= '0;
            burst_q  <= 1'b0;
            btype_q  <= 1'b0;
            run_q    <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pwm_in_q <= PwmIn;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start && !Stop && (eff_len != '0)) begin
                        state_q <= ST_LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        run_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (Stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        run_q   <= 1'b0;
                    end else begin
                        period_q <= tbl_period_q[idx_q];
                        duty_q   <= ld_duty;
                        burst_q  <= tbl_burst_q[idx_q];
                        btype_q  <= tbl_btype_q[idx_q];
                        cnt_q    <= ld_count;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        run_q   <= 1'b0;
                    end else if (rise) begin
                        if (cnt_q == CNT_ONE) begin
                            if (has_next) begin
                                idx_q   <= idx_q + AW'(1);
                                state_q <= ST_LOAD;
                            end else if (Loop) begin
                                idx_q   <= '0;
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                run_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            // counter is never below 1 here, so this cannot wrap
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Period    = period_q;
    assign DutyCycle = duty_q;
    assign Burst     = burst_q;
    assign BurstType = btype_q;
    assign PwmRun    = run_q;
    assign StepIdx   = idx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: expected step settings are queued when Start is driven
// and popped each time the sequencer loads a step.
module tb_pwm_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int AW    = 3;

    logic             SysClk;
    logic             Reset;
    logic             WrEn;
    logic [AW-1:0]    WrAddr;
    logic [15:0]      WrPeriod;
    logic [7:0]       WrDuty;
    logic             WrBurst;
    logic             WrBurstType;
    logic [CNT_W-1:0] WrCount;
    logic [AW:0]      Length;
    logic             Loop;
    logic             Start;
    logic             Stop;
    logic             PwmIn;
    logic [15:0]      Period;
    logic [7:0]       DutyCycle;
    logic             Burst;
    logic             BurstType;
    logic             PwmRun;
    logic [AW-1:0]    StepIdx;
    logic             Busy;
    logic             Done;

    pwm_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .SysClk(SysClk), .Reset(Reset),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrPeriod(WrPeriod), .WrDuty(WrDuty),
        .WrBurst(WrBurst), .WrBurstType(WrBurstType), .WrCount(WrCount),
        .Length(Length), .Loop(Loop), .Start(Start), .Stop(Stop), .PwmIn(PwmIn),
        .Period(Period), .DutyCycle(DutyCycle), .Burst(Burst), .BurstType(BurstType),
        .PwmRun(PwmRun), .StepIdx(StepIdx), .Busy(Busy), .Done(Done)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    typedef struct {
        logic [15:0]   period;
        logic [7:0]    duty;
        logic [AW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;

    // Done is a full-cycle pulse, so the falling edge sees each one exactly once
    always @(negedge SysClk) if (Done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic rise_tick();
        PwmIn = 1'b1;
        tick();
    endtask

    task automatic fall_tick();
        PwmIn = 1'b0;
        tick();
    endtask

    task automatic pulse();
        rise_tick();
        fall_tick();
    endtask

    task automatic wr(input int addr, input int per, input int duty, input int b,
                      input int bt, input int cnt);
        WrEn        = 1'b1;
        WrAddr      = AW'(addr);
        WrPeriod    = 16'(per);
        WrDuty      = 8'(duty);
        WrBurst     = 1'(b);
        WrBurstType = 1'(bt);
        WrCount     = CNT_W'(cnt);
        tick();
        WrEn        = 1'b0;
    endtask

    task automatic push(input int per, input int duty, input int idx);
        exp_t e;
        e.period = 16'(per);
        e.duty   = 8'(duty);
        e.idx    = AW'(idx);
        exp_q.push_back(e);
    endtask

    task automatic check_step(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed load with empty scoreboard, expected none", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_period"}, 32'(Period), 32'(e.period));
            chk({tag, "_duty"}, 32'(DutyCycle), 32'(e.duty));
            chk({tag, "_idx"}, 32'(StepIdx), 32'(e.idx));
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_run"}, 32'(PwmRun), 32'd1);
        end
    endtask

    task automatic start_play();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b0; WrEn = 1'b0; WrAddr = '0; WrPeriod = '0; WrDuty = '0;
        WrBurst = 1'b0; WrBurstType = 1'b0; WrCount = '0;
        Length = 4'd2; Loop = 1'b0; Start = 1'b1; Stop = 1'b0; PwmIn = 1'b0;

        // Reset held with Start asserted
        repeat (3) tick();
        chk("rst_period", 32'(Period), 32'd0);
        chk("rst_duty", 32'(DutyCycle), 32'd0);
        chk("rst_run", 32'(PwmRun), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_idx", 32'(StepIdx), 32'd0);
        Reset = 1'b1;
        tick();
        chk("rel_busy", 32'(Busy), 32'd1);
        chk("rel_run", 32'(PwmRun), 32'd1);
        chk("rel_idx", 32'(StepIdx), 32'd0);
        Start = 1'b0;
        Stop  = 1'b1;
        tick();
        chk("rel_stop_busy", 32'(Busy), 32'd0);
        chk("rel_stop_run", 32'(PwmRun), 32'd0);
        Stop = 1'b0;

        // One-shot over two entries
        wr(0, 1000, 50, 1, 0, 3);
        wr(1, 200, 25, 0, 1, 2);
        Length = 4'd2; Loop = 1'b0;
        push(1000, 50, 0); push(200, 25, 1);
        start_play();
        check_step("os_s0");
        chk("os_burst0", 32'(Burst), 32'd1);
        chk("os_btype0", 32'(BurstType), 32'd0);
        pulse();
        chk("os_hold1", 32'(Period), 32'd1000);
        pulse();
        chk("os_hold2", 32'(Period), 32'd1000);
        pulse();
        check_step("os_s1");
        chk("os_burst1", 32'(Burst), 32'd0);
        chk("os_btype1", 32'(BurstType), 32'd1);
        pulse();
        chk("os_hold3", 32'(Period), 32'd200);
        rise_tick();
        exp_done++;
        chk("os_done", 32'(Done), 32'd1);
        chk("os_end_run", 32'(PwmRun), 32'd0);
        chk("os_end_busy", 32'(Busy), 32'd0);
        chk("os_end_period", 32'(Period), 32'd200);
        fall_tick();
        chk("os_done_clr", 32'(Done), 32'd0);
        tick();
        chk("os_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Looping, Start ignored while busy, rewrite of the active entry
        Loop = 1'b1;
        push(1000, 50, 0); push(200, 25, 1); push(1000, 50, 0);
        push(200, 25, 1); push(3333, 60, 0);
        start_play();
        check_step("lp_a0");
        repeat (3) pulse();
        check_step("lp_a1");
        repeat (2) pulse();
        check_step("lp_b0");
        Start = 1'b1;
        pulse();
        chk("lp_start_idx", 32'(StepIdx), 32'd0);
        chk("lp_start_period", 32'(Period), 32'd1000);
        Start = 1'b0;
        wr(0, 3333, 60, 0, 0, 3);
        chk("lp_rewrite_hold", 32'(Period), 32'd1000);
        chk("lp_rewrite_duty", 32'(DutyCycle), 32'd50);
        repeat (2) pulse();
        check_step("lp_b1");
        repeat (2) pulse();
        check_step("lp_c0");
        chk("lp_no_done", 32'(done_cnt), 32'(exp_done));
        Stop = 1'b1;
        tick();
        chk("lp_stop_run", 32'(PwmRun), 32'd0);
        chk("lp_stop_busy", 32'(Busy), 32'd0);
        Stop = 1'b0;

        // Duty clamp, zero count, Stop colliding with the final rise
        wr(0, 500, 150, 1, 1, 0);
        wr(1, 700, 10, 0, 0, 1);
        Loop = 1'b0;
        push(500, 100, 0); push(700, 10, 1);
        start_play();
        check_step("cl_s0");
        pulse();
        check_step("cl_s1");
        Stop = 1'b1;
        rise_tick();
        chk("cl_stop_busy", 32'(Busy), 32'd0);
        chk("cl_stop_done", 32'(Done), 32'd0);
        Stop = 1'b0;
        fall_tick();
        chk("cl_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Zero length, and Start together with Stop in IDLE
        Length = 4'd0;
        Start  = 1'b1;
        repeat (2) tick();
        chk("len0_busy", 32'(Busy), 32'd0);
        chk("len0_run", 32'(PwmRun), 32'd0);
        Length = 4'd2;
        Stop   = 1'b1;
        repeat (2) tick();
        chk("ss_busy", 32'(Busy), 32'd0);
        Start = 1'b0;
        Stop  = 1'b0;

        // Length above DEPTH plays every entry once
        for (int i = 0; i < DEPTH; i++) wr(i, 100 + i, 10 * i, 0, 0, 1);
        Length = 4'd12;
        for (int i = 0; i < DEPTH; i++) push(100 + i, 10 * i, i);
        start_play();
        for (int i = 0; i < DEPTH; i++) begin
            check_step($sformatf("l12_s%0d", i));
            rise_tick();
            if (i < DEPTH - 1) fall_tick();
        end
        exp_done++;
        chk("l12_done", 32'(Done), 32'd1);
        fall_tick();
        chk("l12_done_cnt", 32'(done_cnt), 32'(exp_done));

        // Asynchronous reset in the middle of RUN
        Length = 4'd2;
        push(100, 0, 0); push(101, 10, 1);
        start_play();
        check_step("ar_s0");
        pulse();
        check_step("ar_s1");
        #3;
        Reset = 1'b0;
        #1;
        chk("ar_period", 32'(Period), 32'd0);
        chk("ar_duty", 32'(DutyCycle), 32'd0);
        chk("ar_run", 32'(PwmRun), 32'd0);
        chk("ar_busy", 32'(Busy), 32'd0);
        chk("ar_idx", 32'(StepIdx), 32'd0);
        #2;
        Reset = 1'b1;
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
